pla_vg_match_pipe: RTL and testbench
====================================

# pla_vg_match_pipe

Pipelined, parametrised successor to the vg2 select/compare PLA. Each beat selects one of three per-channel hi/lo source pairs by mode, tests a shared FW-bit field for all-ones, all-zeros and less-than-threshold, and produces per-channel hit flags. The block adds a valid/ready handshake, a 2-stage pipeline and saturating per-channel hit counters. It sits between the mode/field decode logic and the downstream status collector.

## Interface
- CH, 2: number of channels.
- FW, 14: field width in bits.
- CNT_W, 8: hit-counter width per channel.

- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- mode  in  2  source select: 0=src0, 1=src1, 2=src2, 3=none (all selects 0).
- hi_in  in  3*CH  hi bits; bit [s*CH+c] is source s, channel c.
- lo_in  in  3*CH  lo bits, same packing as hi_in.
- field  in  FW  compared field.
- thresh  in  FW  unsigned threshold.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- hi_sel  out  CH  selected hi bits.
- lo_sel  out  CH  selected lo bits.
- ones_hit  out  CH  hi_sel & (field all ones).
- zeros_hit  out  CH  lo_sel & (field all zeros).
- cmp_hit  out  CH  (hi_sel & field<thresh) | (lo_sel & field>=thresh).
- cnt_clr  in  1  synchronous clear of all counters.
- hit_cnt  out  CH*CNT_W  per-channel saturating count; channel c at [c*CNT_W +: CNT_W].

## Operation
- Stage 1 (on accept): register hi_sel/lo_sel from mode, plus field flags all1, all0, lt (field<thresh, unsigned).
- Stage 2: register the per-channel combination into ones_hit, zeros_hit, cmp_hit; carry hi_sel/lo_sel.
- mode=3: hi_sel=lo_sel=0, so all hits are 0; the beat still flows and counts as a beat.
- Counter c increments by 1 on each output transfer (out_valid & out_ready) where ones_hit[c] | zeros_hit[c].
- Counters saturate at 2^CNT_W-1 and never wrap.
- cnt_clr zeroes all counters. It has priority over a simultaneous increment: the result is 0, not 1.
- FW=1 is legal. In that case all1 = field and all0 = ~field.

## Timing
- Reset values: out_valid=0, in_ready=1, hi_sel/lo_sel/all hits=0, hit_cnt=0, both stage valids=0.
- Latency: 2 cycles from accepted input to out_valid when downstream does not stall.
- Throughput: 1 beat/cycle while out_ready=1.
- s2 advances when !s2_valid | out_ready.
- s1 advances when !s1_valid | s2 advance.
- in_ready = s1 advance, computed combinationally from out_ready and stage valids. This path is registered-free by design.
- While out_valid=1 and out_ready=0, all outputs hold stable, and at most 2 beats are buffered.
- An input is transferred only when in_valid & in_ready. Inputs are ignored otherwise.
- Reset asserted mid-flight drops all buffered beats and clears counters asynchronously. The first accept after reset deassertion behaves as from idle.

## Structure
- Package pla_vg_pkg holds:
  - mode encodings: MODE_SRC0..MODE_SRC2, MODE_NONE;
  - the packed-index helper for hi_in/lo_in;
  - the stage-1 struct: hi, lo, all1, all0, lt.
- One sub-module, pla_vg_sat_cnt: a single CNT_W saturating counter with clr and inc, instantiated CH times.
- The selection and compare logic stays inline in pla_vg_match_pipe.

## Test plan
- Basic pass: CH=2, FW=14, mode=0, hi_in[0]=1, field=14'h3FFF, out_ready=1. Expect out_valid 2 cycles later with ones_hit=2'b01, cmp_hit=0 (field not < thresh=0x10), and hit_cnt[0]=1 after the transfer.
- Zeros/compare: mode=2, lo_in bits for source 2 = 2'b11, field=0, thresh=0. Expect zeros_hit=2'b11 and cmp_hit=2'b11 (0>=0); both counters increment.
- Backpressure: stream 4 beats with out_ready=0. Expect in_ready to drop after 2 accepts and outputs to hold stable. Releasing out_ready drains the beats in order with no loss or duplication.
- Saturation/clear: CNT_W=2, 5 hitting beats. Expect hit_cnt to stick at 3. Asserting cnt_clr on the same cycle as a hitting transfer yields 0.
- mode=3 with all hi/lo inputs =1 and field all ones. Expect every hit flag 0, out_valid to still pulse, and counters unchanged.
- Async reset while 2 beats are buffered. Expect out_valid=0 and hit_cnt=0 immediately, before the next clk edge, and in_ready=1 once rst deasserts.

Source files
------------

// File: rtl/pla_vg_pkg.sv
// -----------------------------------------------------------------------------
// pla_vg_pkg
//
// Shared definitions for the pipelined vg select/compare PLA.
//   - PLA_CH      : channel count the stage-1 record is sized for
//   - NUM_SRC     : number of selectable hi/lo source pairs
//   - mode_e      : source-select encodings carried on the 'mode' input
//   - src_bit()   : packed bit index of (source, channel) inside hi_in/lo_in
//   - s1_t        : stage-1 pipeline record (selected bits plus field flags)
// -----------------------------------------------------------------------------
package pla_vg_pkg;

    localparam int PLA_CH  = 2;
    localparam int NUM_SRC = 3;

    typedef enum logic [1:0] {
        MODE_SRC0 = 2'd0,
        MODE_SRC1 = 2'd1,
        MODE_SRC2 = 2'd2,
        MODE_NONE = 2'd3
    } mode_e;

    // hi_in/lo_in are packed source-major: bit [s*ch + c] is source s, channel c.
    function automatic int src_bit(input int s, input int c, input int ch);
        return s * ch + c;
    endfunction

    // Stage-1 record. The hi/lo vectors are sized by PLA_CH, so the top-level
    // CH parameter is expected to match PLA_CH.
    typedef struct packed {
        logic [PLA_CH-1:0] hi;
        logic [PLA_CH-1:0] lo;
        logic              all1;
        logic              all0;
        logic              lt;
    } s1_t;

endpackage

// File: rtl/pla_vg_sat_cnt.sv
// -----------------------------------------------------------------------------
// pla_vg_sat_cnt
//
// Single saturating up-counter used once per channel for hit counting.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears the count
//   clr  : synchronous clear, wins over a simultaneous increment
//   inc  : add one this cycle unless already at all-ones
//   cnt  : current count (CNT_W bits)
// -----------------------------------------------------------------------------
module pla_vg_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Clear has priority so a clear on a hitting transfer lands at zero;
    // the count sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pla_vg_match_pipe.sv
// -----------------------------------------------------------------------------
// pla_vg_match_pipe
//
// Two-stage pipelined select/compare PLA with valid/ready handshake and
// per-channel saturating hit counters.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : input handshake (in_ready is combinational)
//   mode                  : source select, 0..2 = src0..src2, 3 = none
//   hi_in, lo_in          : 3*CH source bits, bit [s*CH+c] = source s, chan c
//   field, thresh         : FW-bit field and unsigned threshold
//   out_valid / out_ready : output handshake
//   hi_sel, lo_sel        : selected hi/lo bits per channel
//   ones_hit              : hi_sel & field all ones
//   zeros_hit             : lo_sel & field all zeros
//   cmp_hit               : (hi_sel & field<thresh) | (lo_sel & field>=thresh)
//   cnt_clr               : synchronous clear of all hit counters
//   hit_cnt               : per-channel counts, channel c at [c*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module pla_vg_match_pipe
    import pla_vg_pkg::*;
#(
    parameter int CH    = PLA_CH,
    parameter int FW    = 14,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            mode,
    input  logic [NUM_SRC*CH-1:0] hi_in,
    input  logic [NUM_SRC*CH-1:0] lo_in,
    input  logic [FW-1:0]         field,
    input  logic [FW-1:0]         thresh,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH-1:0]         hi_sel,
    output logic [CH-1:0]         lo_sel,
    output logic [CH-1:0]         ones_hit,
    output logic [CH-1:0]         zeros_hit,
    output logic [CH-1:0]         cmp_hit,
    input  logic                  cnt_clr,
    output logic [CH*CNT_W-1:0]   hit_cnt
);

    localparam int SRC0_LSB = src_bit(0, 0, CH);
    localparam int SRC1_LSB = src_bit(1, 0, CH);
    localparam int SRC2_LSB = src_bit(2, 0, CH);

    // Handshake
    logic s1_adv;
    logic s2_adv;
    logic out_xfer;

    // Stage 1 state
    logic s1_valid_d;
    logic s1_valid_q;
    s1_t  s1_data_d;
    s1_t  s1_data_q;

    // Stage 2 state
    logic          s2_valid_d;
    logic          s2_valid_q;
    logic [CH-1:0] s2_hi_d;
    logic [CH-1:0] s2_hi_q;
    logic [CH-1:0] s2_lo_d;
    logic [CH-1:0] s2_lo_q;
    logic [CH-1:0] s2_ones_d;
    logic [CH-1:0] s2_ones_q;
    logic [CH-1:0] s2_zeros_d;
    logic [CH-1:0] s2_zeros_q;
    logic [CH-1:0] s2_cmp_d;
    logic [CH-1:0] s2_cmp_q;

    // Combinational stage-1 inputs
    logic [CH-1:0] sel_hi;
    logic [CH-1:0] sel_lo;
    logic          fld_all1;
    logic          fld_all0;
    logic          fld_lt;

    logic [CH-1:0] cnt_inc;

    // A stage may move when it is empty or the stage after it is moving.
    // in_ready deliberately comes straight from out_ready and the stage
    // valids so a full pipe can still accept on the cycle it drains.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        out_xfer = s2_valid_q && out_ready;
    end

    assign in_ready = s1_adv;

    // Source selection; MODE_NONE (and anything unlisted) selects nothing,
    // which forces every hit flag low while the beat still flows.
    always_comb begin
        sel_hi = '0;
        sel_lo = '0;
        case (mode)
            MODE_SRC0: begin
                sel_hi = hi_in[SRC0_LSB +: CH];
                sel_lo = lo_in[SRC0_LSB +: CH];
            end
            MODE_SRC1: begin
                sel_hi = hi_in[SRC1_LSB +: CH];
                sel_lo = lo_in[SRC1_LSB +: CH];
            end
            MODE_SRC2: begin
                sel_hi = hi_in[SRC2_LSB +: CH];
                sel_lo = lo_in[SRC2_LSB +: CH];
            end
            default: begin
                sel_hi = '0;
                sel_lo = '0;
            end
        endcase
    end

    // Field flags. Reduction operators keep FW=1 correct: all1 = field,
    // all0 = ~field.
    always_comb begin
        fld_all1 = &field;
        fld_all0 = ~|field;
        fld_lt   = (field < thresh);
    end

    // Stage 1 loads only on an accepted beat; when it moves without a new
    // beat it just goes empty and keeps its stale payload.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d.hi   = sel_hi;
                s1_data_d.lo   = sel_lo;
                s1_data_d.all1 = fld_all1;
                s1_data_d.all0 = fld_all0;
                s1_data_d.lt   = fld_lt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    // Stage 2 combines the per-channel selects with the shared field flags.
    // Payload is only replaced by a valid stage-1 beat, so outputs stay
    // stable while the downstream stalls.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_hi_d    = s2_hi_q;
        s2_lo_d    = s2_lo_q;
        s2_ones_d  = s2_ones_q;
        s2_zeros_d = s2_zeros_q;
        s2_cmp_d   = s2_cmp_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_hi_d    = s1_data_q.hi;
                s2_lo_d    = s1_data_q.lo;
                s2_ones_d  = s1_data_q.hi & {CH{s1_data_q.all1}};
                s2_zeros_d = s1_data_q.lo & {CH{s1_data_q.all0}};
                s2_cmp_d   = (s1_data_q.hi & {CH{s1_data_q.lt}})
                           | (s1_data_q.lo & {CH{~s1_data_q.lt}});
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_hi_q    <= '0;
            s2_lo_q    <= '0;
            s2_ones_q  <= '0;
            s2_zeros_q <= '0;
            s2_cmp_q   <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_hi_q    <= s2_hi_d;
            s2_lo_q    <= s2_lo_d;
            s2_ones_q  <= s2_ones_d;
            s2_zeros_q <= s2_zeros_d;
            s2_cmp_q   <= s2_cmp_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign hi_sel    = s2_hi_q;
    assign lo_sel    = s2_lo_q;
    assign ones_hit  = s2_ones_q;
    assign zeros_hit = s2_zeros_q;
    assign cmp_hit   = s2_cmp_q;

    // A channel counts a beat only when it leaves the block with a ones or
    // zeros hit; compare hits do not count.
    always_comb begin
        cnt_inc = {CH{out_xfer}} & (s2_ones_q | s2_zeros_q);
    end

    for (genvar c = 0; c < CH; c++) begin : g_cnt
        pla_vg_sat_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (cnt_clr),
            .inc (cnt_inc[c]),
            .cnt (hit_cnt[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_pla_vg_match_pipe.sv
// -----------------------------------------------------------------------------
// tb_pla_vg_match_pipe
//
// Directed bench for pla_vg_match_pipe (CH=2, FW=14, CNT_W=2). The stimulus
// side pushes hand-computed expected beats into a scoreboard queue; a monitor
// on the falling edge pops and compares whenever a beat leaves the DUT and
// tracks the expected counter values.
// -----------------------------------------------------------------------------
module tb_pla_vg_match_pipe;

    localparam int CH    = 2;
    localparam int FW    = 14;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          mode;
    logic [3*CH-1:0]     hi_in;
    logic [3*CH-1:0]     lo_in;
    logic [FW-1:0]       field;
    logic [FW-1:0]       thresh;
    logic                out_valid;
    logic                out_ready;
    logic [CH-1:0]       hi_sel;
    logic [CH-1:0]       lo_sel;
    logic [CH-1:0]       ones_hit;
    logic [CH-1:0]       zeros_hit;
    logic [CH-1:0]       cmp_hit;
    logic                cnt_clr;
    logic [CH*CNT_W-1:0] hit_cnt;

    typedef struct {
        logic [1:0]    mode;
        logic [5:0]    hi_in;
        logic [5:0]    lo_in;
        logic [13:0]   field;
        logic [13:0]   thresh;
        logic [1:0]    e_hi;
        logic [1:0]    e_lo;
        logic [1:0]    e_ones;
        logic [1:0]    e_zeros;
        logic [1:0]    e_cmp;
    } vec_t;

    typedef struct {
        logic [1:0] hi;
        logic [1:0] lo;
        logic [1:0] ones;
        logic [1:0] zeros;
        logic [1:0] cmp;
    } exp_t;

    vec_t vecs[6];
    exp_t sb_q[$];
    int   exp_cnt[CH];
    int   n_cmp;
    int   n_fail;

    pla_vg_match_pipe #(
        .CH    (CH),
        .FW    (FW),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .hi_in     (hi_in),
        .lo_in     (lo_in),
        .field     (field),
        .thresh    (thresh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hi_sel    (hi_sel),
        .lo_sel    (lo_sel),
        .ones_hit  (ones_hit),
        .zeros_hit (zeros_hit),
        .cmp_hit   (cmp_hit),
        .cnt_clr   (cnt_clr),
        .hit_cnt   (hit_cnt)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a wedged run still ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: timed out (got no event, expected one) at %0t", name, $time);
    endtask

    // Drive vector idx and hold it until the DUT takes it; push the expected
    // beat on the cycle it is accepted. Returns 1 unit after the accept edge.
    task automatic applyStimulus(input int idx);
        exp_t e;
        bit   got;
        got      = 1'b0;
        mode     = vecs[idx].mode;
        hi_in    = vecs[idx].hi_in;
        lo_in    = vecs[idx].lo_in;
        field    = vecs[idx].field;
        thresh   = vecs[idx].thresh;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.hi    = vecs[idx].e_hi;
                e.lo    = vecs[idx].e_lo;
                e.ones  = vecs[idx].e_ones;
                e.zeros = vecs[idx].e_zeros;
                e.cmp   = vecs[idx].e_cmp;
                sb_q.push_back(e);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) timeoutFail("accept");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) done = 1'b1;
        end
        if (!done) timeoutFail("drain");
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            for (int c = 0; c < CH; c++) exp_cnt[c] = 0;
        end else begin
            for (int c = 0; c < CH; c++)
                checkOutput("hit_cnt", 32'(hit_cnt[c*CNT_W +: CNT_W]), 32'(exp_cnt[c]));
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    timeoutFail("unexpected_out_valid");
                end else begin
                    e = sb_q[0];
                    checkOutput("hi_sel",    32'(hi_sel),    32'(e.hi));
                    checkOutput("lo_sel",    32'(lo_sel),    32'(e.lo));
                    checkOutput("ones_hit",  32'(ones_hit),  32'(e.ones));
                    checkOutput("zeros_hit", 32'(zeros_hit), 32'(e.zeros));
                    checkOutput("cmp_hit",   32'(cmp_hit),   32'(e.cmp));
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        for (int c = 0; c < CH; c++)
                            if ((e.ones[c] || e.zeros[c]) && exp_cnt[c] < CMAX)
                                exp_cnt[c]++;
                    end
                end
            end
            if (cnt_clr) begin
                for (int c = 0; c < CH; c++) exp_cnt[c] = 0;
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int c = 0; c < CH; c++) exp_cnt[c] = 0;

        //            mode  hi_in      lo_in      field     thresh    hi     lo     ones   zeros  cmp
        vecs[0] = '{2'd0, 6'b000001, 6'b000000, 14'h3FFF, 14'h0010, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00};
        vecs[1] = '{2'd2, 6'b000000, 6'b110000, 14'h0000, 14'h0000, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
        vecs[2] = '{2'd1, 6'b001000, 6'b000100, 14'h0005, 14'h0100, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10};
        vecs[3] = '{2'd3, 6'b111111, 6'b111111, 14'h3FFF, 14'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[4] = '{2'd0, 6'b000010, 6'b000001, 14'h3FFF, 14'h3FFF, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01};
        vecs[5] = '{2'd0, 6'b000011, 6'b000000, 14'h0FFF, 14'h1000, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11};

        rst       = 1'b1;
        in_valid  = 1'b0;
        mode      = '0;
        hi_in     = '0;
        lo_in     = '0;
        field     = '0;
        thresh    = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        // Reset values
        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_hit_cnt",   32'(hit_cnt),   32'd0);
        checkOutput("rst_hi_sel",    32'(hi_sel),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic pass plus two-cycle latency
        applyStimulus(0);
        @(negedge clk);
        checkOutput("latency_s1", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("latency_s2", 32'(out_valid), 32'd1);
        drain();
        checkOutput("basic_cnt", 32'(hit_cnt), 32'h1);

        // Back-to-back stream of the remaining patterns
        for (int i = 1; i < 6; i++) applyStimulus(i);
        drain();

        // Backpressure: two accepts fill the pipe, the rest wait for release
        out_ready = 1'b0;
        applyStimulus(0);
        applyStimulus(1);
        @(negedge clk);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        fork
            begin
                applyStimulus(2);
                applyStimulus(4);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Saturation of channel 0
        for (int i = 0; i < 5; i++) applyStimulus(0);
        drain();
        checkOutput("sat_cnt0", 32'(hit_cnt[0 +: CNT_W]), 32'(CMAX));

        // Clear on the same edge as a hitting transfer
        applyStimulus(0);
        @(negedge clk);
        @(posedge clk);
        #1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        checkOutput("clr_priority", 32'(hit_cnt), 32'd0);
        drain();

        // mode=3 flows but never hits
        applyStimulus(3);
        drain();
        checkOutput("none_cnt", 32'(hit_cnt), 32'd0);

        // Give both counters a nonzero value, then reset with two beats held
        applyStimulus(1);
        drain();
        out_ready = 1'b0;
        applyStimulus(0);
        applyStimulus(1);
        checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #2;
        checkOutput("async_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_hit_cnt",   32'(hit_cnt),   32'd0);
        sb_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 32'(in_ready),  32'd1);
        checkOutput("post_rst_valid",    32'(out_valid), 32'd0);
        out_ready = 1'b1;
        applyStimulus(4);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
